// File: rtl/dcache_dma_engine.sv
// dcache_dma_engine: moves word streams between the stream ports and one dcache
// slot. LOAD writes incoming stream words into the dcache; STORE reads words out
// of the dcache through a small credit-managed FIFO onto the outgoing stream.

package dcache_dma_pkg;

  typedef struct packed {
    logic [1:0]  slot;
    logic [10:0] addr;
    logic        we;
    logic [17:0] dat_w;
  } dcache_write_port_dma;

  typedef struct packed {
    logic [1:0]  slot;
    logic [10:0] addr;
    logic        re;
  } dcache_read_port_dma_1;

  typedef struct packed {
    logic [17:0] dat_r;
    logic        read_complete;
  } dcache_read_port_dma_2;

endpackage

module dcache_dma_engine
  import dcache_dma_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int LEN_W      = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_dir,
  input  logic [1:0]            cmd_slot,
  input  logic [10:0]           cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [17:0]           in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [17:0]           out_data,
  output dcache_write_port_dma  dma_write_port,
  output dcache_read_port_dma_1 dma_read_port_in,
  input  dcache_read_port_dma_2 dma_read_port_out,
  output logic                  busy,
  output logic                  done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    DRAIN,
    DONE
  } state_t;

  state_t                state_q;
  state_t                state_d;

  logic [1:0]            slot_q;
  logic [10:0]           addr_q;
  logic [LEN_W-1:0]      rem_q;

  // Reads issued but not yet returned, and words sitting in the FIFO.
  // Their sum never exceeds FIFO_DEPTH, which is what keeps the FIFO safe.
  logic [CNT_W-1:0]      outst_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [17:0]           fifo_mem [FIFO_DEPTH];

  dcache_write_port_dma  wr_port_q;
  dcache_read_port_dma_1 rd_port_q;

  logic                  accept;
  logic                  load_beat;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  credit_ok;
  logic [CNT_W:0]        credit_used;

  assign dma_write_port   = wr_port_q;
  assign dma_read_port_in = rd_port_q;

  // FIFO status, credit check and the legal-return filter for read data.
  always_comb begin
    credit_used = {1'b0, outst_q} + {1'b0, cnt_q};
    credit_ok   = (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    out_valid   = (cnt_q != '0);
    out_data    = fifo_mem[rd_ptr_q];
    pop         = out_valid && out_ready;
    // A completion with nothing outstanding (e.g. a read that was in flight
    // across a reset) is dropped here.
    push        = ((state_q == STORE) || (state_q == DRAIN)) &&
                  dma_read_port_out.read_complete && (outst_q != '0);
  end

  // Next-state logic plus the per-cycle handshake strobes.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    load_beat = 1'b0;
    issue     = 1'b0;
    cmd_ready = (state_q == IDLE);
    in_ready  = 1'b0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_len == '0) begin
            state_d = DONE;
          end else if (cmd_dir) begin
            state_d = STORE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        // The last beat leaves remaining at 0 for one cycle while its write
        // is on the port, so done lands one cycle after the final we.
        if (rem_q == '0) begin
          state_d = DONE;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            load_beat = 1'b1;
          end
        end
      end
      STORE: begin
        if (rem_q == '0) begin
          state_d = DRAIN;
        end else if (credit_ok) begin
          issue = 1'b1;
          if (rem_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if ((outst_q == '0) && (cnt_q == '0)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command latch and the walking address / remaining count (11-bit wrap).
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '0;
      addr_q <= '0;
      rem_q  <= '0;
    end else if (accept) begin
      slot_q <= cmd_slot;
      addr_q <= cmd_addr;
      rem_q  <= cmd_len;
    end else if (load_beat || issue) begin
      addr_q <= addr_q + 11'd1;
      rem_q  <= rem_q - 1'b1;
    end
  end

  // Registered dcache write and read requests; we/re are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_port_q <= '0;
      rd_port_q <= '0;
    end else begin
      wr_port_q.we <= 1'b0;
      rd_port_q.re <= 1'b0;
      if (load_beat) begin
        wr_port_q <= '{slot: slot_q, addr: addr_q, we: 1'b1, dat_w: in_data};
      end
      if (issue) begin
        rd_port_q <= '{slot: slot_q, addr: addr_q, re: 1'b1};
      end
    end
  end

  // Outstanding-read counter: up on issue, down on each accepted completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      outst_q <= '0;
    end else begin
      unique case ({issue, push})
        2'b10:   outst_q <= outst_q + 1'b1;
        2'b01:   outst_q <= outst_q - 1'b1;
        default: outst_q <= outst_q;
      endcase
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop nets to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= dma_read_port_out.dat_r;
    end
  end

endmodule

// File: doc/dcache_dma_engine.md
DCACHE_DMA_ENGINE -- requirements
Module: dcache_dma_engine

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning store-path output buffer depth in 18-bit words; legal values are powers of two of at least 2.
REQ-002 SHALL have parameter LEN_W, default 12, meaning the width of cmd_len.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port `clk`: input, 1 bit, the sole clock.
REQ-005 SHALL have port `reset`: input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port `cmd_valid`: input, 1 bit, command offered.
REQ-007 SHALL have port `cmd_ready`: output, 1 bit, the engine accepts a command.
REQ-008 SHALL have port `cmd_dir`: input, 1 bit; 0 is LOAD (stream into dcache), 1 is STORE (dcache out to stream).
REQ-009 SHALL have port `cmd_slot`: input, 2 bits, dcache slot.
REQ-010 SHALL have port `cmd_addr`: input, 11 bits, start word address.
REQ-011 SHALL have port `cmd_len`: input, LEN_W bits, word count.
REQ-012 SHALL have port `in_valid`, `in_ready`, `in_data`: input, output, input; 1, 1 and 18 bits; the LOAD data stream.
REQ-013 SHALL have port `out_valid`, `out_ready`, `out_data`: output, input, output; 1, 1 and 18 bits; the STORE data stream.
REQ-014 SHALL have port `dma_write_port`: output, dcache_write_port_dma (slot, addr, we, dat_w).
REQ-015 SHALL have port `dma_read_port_in`: output, dcache_read_port_dma_1 (slot, addr, re).
REQ-016 SHALL have port `dma_read_port_out`: input, dcache_read_port_dma_2 (dat_r, read_complete).
REQ-017 SHALL have port `busy`: output, 1 bit, high when not IDLE.
REQ-018 SHALL have port `done`: output, 1 bit, one-cycle pulse at command completion.

Function
REQ-019 SHALL implement the states IDLE, LOAD, STORE, DRAIN and DONE.
REQ-020 SHALL hold cmd_ready=1 only in IDLE; a command is accepted on a cycle with cmd_valid && cmd_ready.
REQ-021 SHALL latch slot, addr and len on acceptance, then go to LOAD or STORE per cmd_dir; if cmd_len==0, it SHALL go directly to DONE.
REQ-022 LOAD: in_ready SHALL be 1 in LOAD while remaining>0 and combinationally 0 elsewhere.
REQ-023 LOAD: each in_valid && in_ready beat SHALL register, for the next cycle, we=1, addr=current address, slot=latched slot and dat_w=in_data; it SHALL then increment the address and decrement remaining.
REQ-024 LOAD: we SHALL be registered high for exactly one cycle per accepted beat and 0 otherwise; the last beat SHALL move to DONE.
REQ-025 STORE: the engine SHALL assert re (registered, one cycle) with the current address and slot when remaining>0 and (outstanding reads + FIFO occupancy) < FIFO_DEPTH, then increment the address and decrement remaining.
REQ-026 STORE: every read_complete==1 SHALL push dat_r into the FIFO; the FIFO SHALL never overflow, because the credit rule guarantees space.
REQ-027 STORE: out_valid SHALL equal FIFO non-empty; out_data SHALL be the FIFO head; out_valid && out_ready SHALL pop the FIFO.
REQ-028 STORE: out_valid/out_data SHALL be held stable until accepted.
REQ-029 STORE: push and pop in the same cycle SHALL leave the occupancy unchanged.
REQ-030 STORE: when remaining reaches 0, the engine SHALL go to DRAIN; DRAIN SHALL exit to DONE when no read is outstanding and the FIFO is empty.
REQ-031 The address SHALL be 11-bit and wrap modulo 2048 (2047 -> 0); cmd_len larger than 2048 SHALL be legal and overwrite or reread words after the wrap.
REQ-032 DONE SHALL assert done=1 for one cycle, then return to IDLE; cmd_ready SHALL be 0 during DONE, so back-to-back commands are spaced by at least one cycle.
REQ-033 cmd_valid SHALL be ignored outside IDLE; in/out stream activity outside the matching state SHALL have no effect.
REQ-034 A read_complete arriving with no read outstanding is illegal; the bench SHALL flag it and the engine SHALL ignore it.

Reset
REQ-035 When reset is high at a posedge clk, including mid-command, the engine SHALL go to IDLE, clear remaining, the outstanding count and the FIFO, and set we=0, re=0, done=0, out_valid=0, in_ready=0, busy=0 and cmd_ready=1 from the next cycle.
REQ-036 On reset, the dma port addr/slot/dat_w outputs SHALL go to 0.
REQ-037 A read in flight at reset SHALL be discarded.

Verification
REQ-038 LOAD with slot=2, addr=5, len=3 and data 0x11, 0x22, 0x33 with in_valid always high -> we pulses at addr 5, 6, 7 with those data on consecutive cycles, then done one cycle after the last we.
REQ-039 STORE with slot=2, addr=2046, len=4 against a model dcache with 1-cycle latency and out_ready=1 -> re at addr 2046, 2047, 0, 1; out_data in that order; done once.
REQ-040 STORE with len=6, out_ready=0 for 10 cycles then 1 -> at most FIFO_DEPTH re issued before the stall releases, no data lost or duplicated, 6 beats out in order.
REQ-041 Command with cmd_len=0 -> done one cycle after acceptance; no we or re issued.
REQ-042 Assert reset during a STORE with 2 reads outstanding -> next cycle shows IDLE, cmd_ready=1, out_valid=0; a new LOAD of len=1 completes normally.
REQ-043 cmd_valid held high across a command -> the second command is accepted only in the cycle after done.
